// File: rtl/board_dbg_ctrl_pkg.sv
// Shared types and width helpers for the lab-board front-panel controller.
package board_pkg;

    typedef enum logic {
        IDLE,
        COLLECT
    } load_state_e;

    // Index width able to hold the values 0..n-1, never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    localparam int NUM_PHASES_DEF = 3;
    localparam int NUM_CH_DEF     = 4;
    localparam int PH_IDX_W       = idx_w(NUM_PHASES_DEF + 1);
    localparam int CH_IDX_W       = idx_w(NUM_CH_DEF + 1);

endpackage

// File: rtl/board_dbg_ctrl_if.sv
// Board-side bundle: raw switches/buttons in, loader/display/step outputs back.
interface board_dbg_if
    import board_pkg::*;
#(
    parameter int SW_W       = 32,
    parameter int NUM_PHASES = NUM_PHASES_DEF,
    parameter int NUM_CH     = NUM_CH_DEF,
    parameter int DATA_W     = 32
) ();

    localparam int PH_W = idx_w(NUM_PHASES + 1);
    localparam int CH_W = idx_w(NUM_CH + 1);

    logic [SW_W-1:0]            sw;
    logic                       btn_load;
    logic                       btn_sel;
    logic                       btn_step;
    logic                       load_en;
    logic                       mode_run;
    logic [NUM_CH*DATA_W-1:0]   ch_data;

    logic [NUM_PHASES*SW_W-1:0] load_data;
    logic                       load_valid;
    logic [PH_W-1:0]            load_phase;
    logic [DATA_W-1:0]          disp_data;
    logic                       disp_all8;
    logic [CH_W-1:0]            disp_ch;
    logic                       step_en;

    modport master (
        output sw, btn_load, btn_sel, btn_step, load_en, mode_run, ch_data,
        input  load_data, load_valid, load_phase, disp_data, disp_all8, disp_ch, step_en
    );

    modport slave (
        input  sw, btn_load, btn_sel, btn_step, load_en, mode_run, ch_data,
        output load_data, load_valid, load_phase, disp_data, disp_all8, disp_ch, step_en
    );

endinterface

// File: rtl/board_dbg_ctrl_btn_debounce.sv
// One button: 2-FF synchroniser, stability counter and a registered press pulse
// on each rising edge of the debounced level.
module btn_debounce #(
    parameter int DEB_CYCLES = 20000
) (
    input  logic clk,
    input  logic Rst_n,
    input  logic raw,
    output logic level,
    output logic press
);

    localparam int CNT_W = $clog2(DEB_CYCLES);

    logic             sync1_q, sync2_q;
    logic             level_q, level_d;
    logic             level_prev_q;
    logic             press_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // NOTE: every variable gets a default before the branches so no latch is inferred.
    always_comb begin
        cnt_d   = '0;
        level_d = level_q;
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_W'(DEB_CYCLES - 1)) begin
                level_d = ~level_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its inputs from before the edge, independent of statement order.
    always_ff @(posedge clk) begin
        if (!Rst_n) begin
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            cnt_q        <= '0;
            level_q      <= 1'b0;
            level_prev_q <= 1'b0;
            press_q      <= 1'b0;
        end else begin
            sync1_q      <= raw;
            sync2_q      <= sync1_q;
            cnt_q        <= cnt_d;
            level_q      <= level_d;
            level_prev_q <= level_q;
            press_q      <= level_q & ~level_prev_q;
        end
    end

    assign level = level_q;
    assign press = press_q;

endmodule

// File: rtl/board_dbg_ctrl.sv
// Front-panel controller: debounced buttons, multi-word switch loader,
// display channel selector with lamp-test slot, single-step/free-run step enable.
module board_dbg_ctrl
    import board_pkg::*;
#(
    parameter int SW_W       = 32,
    parameter int NUM_PHASES = NUM_PHASES_DEF,
    parameter int NUM_CH     = NUM_CH_DEF,
    parameter int DATA_W     = 32,
    parameter int DEB_CYCLES = 20000,
    parameter int RUN_DIV    = 50000000
) (
    input logic        clk,
    input logic        Rst_n,
    board_dbg_if.slave bus
);

    localparam int PH_W  = idx_w(NUM_PHASES + 1);
    localparam int CH_W  = idx_w(NUM_CH + 1);
    localparam int DIV_W = idx_w(RUN_DIV);

    // Level-sensitive switches share one synchroniser stage pair.
    logic [SW_W-1:0] sw_meta_q, sw_s_q;
    logic            load_en_meta_q, load_en_s_q;
    logic            mode_meta_q, mode_s_q;

    always_ff @(posedge clk) begin
        if (!Rst_n) begin
            sw_meta_q      <= '0;
            sw_s_q         <= '0;
            load_en_meta_q <= 1'b0;
            load_en_s_q    <= 1'b0;
            mode_meta_q    <= 1'b0;
            mode_s_q       <= 1'b0;
        end else begin
            sw_meta_q      <= bus.sw;
            sw_s_q         <= sw_meta_q;
            load_en_meta_q <= bus.load_en;
            load_en_s_q    <= load_en_meta_q;
            mode_meta_q    <= bus.mode_run;
            mode_s_q       <= mode_meta_q;
        end
    end

    logic       load_press, sel_press, step_press;
    // Debounced levels are kept for future panel LEDs.
    logic [2:0] btn_level_unused;

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_load (
        .clk(clk), .Rst_n(Rst_n), .raw(bus.btn_load),
        .level(btn_level_unused[0]), .press(load_press)
    );

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_sel (
        .clk(clk), .Rst_n(Rst_n), .raw(bus.btn_sel),
        .level(btn_level_unused[1]), .press(sel_press)
    );

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_step (
        .clk(clk), .Rst_n(Rst_n), .raw(bus.btn_step),
        .level(btn_level_unused[2]), .press(step_press)
    );

    load_state_e                state_q;
    logic [PH_W-1:0]            phase_q;
    logic [NUM_PHASES*SW_W-1:0] slots_q;
    logic                       load_valid_q;

    // NOTE: the slot array is small and must read back as zero after reset,
    // so it is reset like ordinary control state rather than left uninitialised.
    always_ff @(posedge clk) begin
        if (!Rst_n) begin
            state_q      <= IDLE;
            phase_q      <= '0;
            slots_q      <= '0;
            load_valid_q <= 1'b0;
        end else begin
            load_valid_q <= 1'b0;
            if (load_press && load_en_s_q) begin
                for (int p = 0; p < NUM_PHASES; p++) begin
                    if (phase_q == PH_W'(p)) begin
                        slots_q[p*SW_W +: SW_W] <= sw_s_q;
                    end
                end
                case (state_q)
                    IDLE: begin
                        if (NUM_PHASES == 1) begin
                            load_valid_q <= 1'b1;
                        end else begin
                            state_q <= COLLECT;
                            phase_q <= PH_W'(1);
                        end
                    end
                    COLLECT: begin
                        if (phase_q == PH_W'(NUM_PHASES - 1)) begin
                            state_q      <= IDLE;
                            phase_q      <= '0;
                            load_valid_q <= 1'b1;
                        end else begin
                            phase_q <= phase_q + 1'b1;
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                        phase_q <= '0;
                    end
                endcase
            end
        end
    end

    logic [CH_W-1:0]   sel_q;
    logic [DATA_W-1:0] disp_data_q, disp_data_d;
    logic              disp_all8_q;

    always_comb begin
        disp_data_d = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (sel_q == CH_W'(k)) begin
                disp_data_d = bus.ch_data[k*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!Rst_n) begin
            sel_q       <= '0;
            disp_data_q <= '0;
            disp_all8_q <= 1'b0;
        end else begin
            if (sel_press) begin
                sel_q <= (sel_q == CH_W'(NUM_CH)) ? '0 : sel_q + 1'b1;
            end
            disp_data_q <= disp_data_d;
            disp_all8_q <= (sel_q == CH_W'(NUM_CH));
        end
    end

    logic [DIV_W-1:0] div_q;
    logic             mode_prev_q;
    logic             step_q;

    // The cycle a switch into run mode is seen only restarts the prescaler.
    always_ff @(posedge clk) begin
        if (!Rst_n) begin
            div_q       <= '0;
            mode_prev_q <= 1'b0;
            step_q      <= 1'b0;
        end else begin
            mode_prev_q <= mode_s_q;
            if (mode_s_q && mode_prev_q) begin
                step_q <= (div_q == DIV_W'(RUN_DIV - 1));
                div_q  <= (div_q == DIV_W'(RUN_DIV - 1)) ? '0 : div_q + 1'b1;
            end else if (mode_s_q) begin
                step_q <= 1'b0;
                div_q  <= '0;
            end else begin
                step_q <= step_press;
                div_q  <= '0;
            end
        end
    end

    assign bus.load_data  = slots_q;
    assign bus.load_valid = load_valid_q;
    assign bus.load_phase = phase_q;
    assign bus.disp_data  = disp_data_q;
    assign bus.disp_all8  = disp_all8_q;
    assign bus.disp_ch    = sel_q;
    assign bus.step_en    = step_q;

endmodule

// File: tb/tb_board_dbg_ctrl.sv
// Self-checking bench for board_dbg_ctrl with short debounce and run divider.
module tb_board_dbg_ctrl;

    localparam int SW_W       = 32;
    localparam int NUM_PHASES = 3;
    localparam int NUM_CH     = 4;
    localparam int DATA_W     = 32;
    localparam int DEB        = 4;
    localparam int RUN_DIV    = 5;

    logic clk = 1'b0;
    logic Rst_n;
    always #5 clk = ~clk;

    board_dbg_if #(
        .SW_W(SW_W), .NUM_PHASES(NUM_PHASES), .NUM_CH(NUM_CH), .DATA_W(DATA_W)
    ) bus ();

    board_dbg_ctrl #(
        .SW_W(SW_W), .NUM_PHASES(NUM_PHASES), .NUM_CH(NUM_CH), .DATA_W(DATA_W),
        .DEB_CYCLES(DEB), .RUN_DIV(RUN_DIV)
    ) u_dut (
        .clk(clk),
        .Rst_n(Rst_n),
        .bus(bus)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard for completed load sequences, plus step pulse bookkeeping.
    logic [NUM_PHASES*SW_W-1:0] exp_q[$];
    logic [NUM_PHASES*SW_W-1:0] sb_exp;
    int valid_cnt = 0;
    int step_cnt  = 0;
    int cyc       = 0;
    int last_step = 0;
    int prev_step = 0;

    always @(negedge clk) begin
        cyc++;
        if (Rst_n && bus.load_valid) begin
            valid_cnt++;
            check("load_valid expected", 128'(exp_q.size() != 0), 128'd1);
            if (exp_q.size() != 0) begin
                sb_exp = exp_q.pop_front();
                check("load_data on valid", bus.load_data, sb_exp);
            end
        end
        if (bus.step_en) begin
            step_cnt++;
            prev_step = last_step;
            last_step = cyc;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_btn(input int which, input logic v);
        case (which)
            0:       bus.btn_load = v;
            1:       bus.btn_sel  = v;
            default: bus.btn_step = v;
        endcase
    endtask

    // Clean press: long enough high and low for the debouncer to accept both edges.
    task automatic press(input int which);
        set_btn(which, 1'b1);
        tick(DEB + 6);
        set_btn(which, 1'b0);
        tick(DEB + 6);
    endtask

    task automatic do_reset();
        bus.btn_load = 1'b0;
        bus.btn_sel  = 1'b0;
        bus.btn_step = 1'b0;
        Rst_n = 1'b0;
        tick(3);
        Rst_n = 1'b1;
        tick(2);
    endtask

    typedef struct {
        logic [SW_W-1:0]                 sw;
        logic [board_pkg::PH_IDX_W-1:0] exp_phase;
    } load_vec_t;

    typedef struct {
        logic [DATA_W-1:0]               exp_data;
        logic                            exp_all8;
        logic [board_pkg::CH_IDX_W-1:0] exp_ch;
    } disp_vec_t;

    load_vec_t lv[3];
    disp_vec_t dv[5];
    logic [NUM_PHASES*SW_W-1:0] held;

    initial begin
        lv[0] = '{32'h1111_1111, 2'd1};
        lv[1] = '{32'h2222_2222, 2'd2};
        lv[2] = '{32'h3333_3333, 2'd0};
        dv[0] = '{32'hBBBB_0002, 1'b0, 3'd1};
        dv[1] = '{32'hCCCC_0003, 1'b0, 3'd2};
        dv[2] = '{32'hDDDD_0004, 1'b0, 3'd3};
        dv[3] = '{32'h0000_0000, 1'b1, 3'd4};
        dv[4] = '{32'hAAAA_0001, 1'b0, 3'd0};

        bus.sw       = '0;
        bus.load_en  = 1'b0;
        bus.mode_run = 1'b0;
        bus.ch_data  = '0;

        // Reset with all buttons held high.
        bus.btn_load = 1'b1;
        bus.btn_sel  = 1'b1;
        bus.btn_step = 1'b1;
        Rst_n = 1'b0;
        tick(3);
        check("rst load_data", bus.load_data, '0);
        check("rst load_valid", bus.load_valid, 0);
        check("rst load_phase", bus.load_phase, 0);
        check("rst disp_data", bus.disp_data, 0);
        check("rst disp_all8", bus.disp_all8, 0);
        check("rst disp_ch", bus.disp_ch, 0);
        check("rst step_en", bus.step_en, 0);
        Rst_n = 1'b1;
        step_cnt = 0;
        for (int i = 0; i < DEB + 3; i++) begin
            tick(1);
            check("post-reset disp_ch", bus.disp_ch, 0);
        end
        check("post-reset step pulses", step_cnt, 0);
        do_reset();

        // Three-phase load, then the same presses with load_en low.
        bus.load_en = 1'b1;
        tick(3);
        for (int i = 0; i < 3; i++) begin
            bus.sw = lv[i].sw;
            if (i == 2) exp_q.push_back({lv[2].sw, lv[1].sw, lv[0].sw});
            press(0);
            check("load_phase", bus.load_phase, lv[i].exp_phase);
        end
        held = {lv[2].sw, lv[1].sw, lv[0].sw};
        check("load_data after sequence", bus.load_data, held);
        check("load_valid count", valid_cnt, 1);
        bus.load_en = 1'b0;
        bus.sw = 32'h4444_4444;
        tick(3);
        for (int i = 0; i < 3; i++) begin
            press(0);
            check("disabled load_phase", bus.load_phase, 0);
        end
        check("disabled load_data", bus.load_data, held);
        check("disabled load_valid count", valid_cnt, 1);

        // Display walk through all channels and the lamp-test slot.
        do_reset();
        bus.ch_data = {32'hDDDD_0004, 32'hCCCC_0003, 32'hBBBB_0002, 32'hAAAA_0001};
        tick(2);
        check("disp ch0 initial", bus.disp_data, 32'hAAAA_0001);
        for (int i = 0; i < 5; i++) begin
            press(1);
            check("disp_data", bus.disp_data, dv[i].exp_data);
            check("disp_all8", bus.disp_all8, dv[i].exp_all8);
            check("disp_ch", bus.disp_ch, dv[i].exp_ch);
        end
        bus.ch_data[31:0] = 32'h1234_5678;
        check("disp before live update", bus.disp_data, 32'hAAAA_0001);
        tick(1);
        check("disp live update", bus.disp_data, 32'h1234_5678);

        // Bouncing select button yields a single press.
        do_reset();
        for (int i = 0; i < 3; i++) begin
            bus.btn_sel = 1'b1;
            tick(2);
            bus.btn_sel = 1'b0;
            tick(2);
        end
        bus.btn_sel = 1'b1;
        tick(DEB + 2);
        check("bounce disp_ch early", bus.disp_ch, 0);
        tick(2);
        check("bounce disp_ch", bus.disp_ch, 1);
        tick(10);
        bus.btn_sel = 1'b0;
        tick(10);
        check("bounce single press", bus.disp_ch, 1);

        // Single step, then free run.
        do_reset();
        step_cnt = 0;
        press(2);
        press(2);
        check("single-step pulses", step_cnt, 2);
        bus.mode_run = 1'b1;
        step_cnt = 0;
        tick(24);
        check("run pulses", step_cnt, 4);
        check("run period", last_step - prev_step, RUN_DIV);
        step_cnt = 0;
        press(2);
        check("run ignores step press", step_cnt, 4);
        bus.mode_run = 1'b0;
        tick(4);
        step_cnt = 0;
        tick(12);
        check("idle after run", step_cnt, 0);
        press(2);
        check("step after run", step_cnt, 1);

        // Reset in the middle of a load sequence.
        do_reset();
        bus.load_en = 1'b1;
        bus.sw = 32'hAAAA_5555;
        tick(3);
        press(0);
        check("mid-load phase", bus.load_phase, 1);
        check("mid-load slot0", bus.load_data, {64'h0, 32'hAAAA_5555});
        Rst_n = 1'b0;
        tick(2);
        check("reset mid-load phase", bus.load_phase, 0);
        check("reset mid-load data", bus.load_data, '0);
        Rst_n = 1'b1;
        tick(3);
        for (int i = 0; i < 3; i++) begin
            bus.sw = 32'(i + 1);
            if (i == 2) exp_q.push_back({32'd3, 32'd2, 32'd1});
            press(0);
            check("reload phase", bus.load_phase, lv[i].exp_phase);
        end
        check("total load_valid count", valid_cnt, 2);
        check("scoreboard drained", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
